ifu: RTL and testbench

Instruction fetch unit feeding the control decoder and register file. Owns the program counter, drives a synchronous-read instruction memory, presents the fetched instruction with its PC to decode, and applies branch, jump and jump-register redirects. Decode returns `PC_sel`/`IsJump` and the ALU branch condition in the same cycle. No branch delay slot: a redirect squashes the one in-flight fetch.

---
 rtl/ifu_pkg.sv | 35 +++
 rtl/ifu_if.sv | 33 +++
 rtl/ifu_npc.sv | 35 +++
 rtl/ifu.sv | 82 ++++++++
 tb/tb_ifu.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ifu_pkg
// Description : Shared encodings for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    // Decoder PC mux select values
    localparam logic [1:0] PC_MUX_SEL_NEWPC  = 2'b00;
    localparam logic [1:0] PC_MUX_SEL_BRANCH = 2'b01;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'd0,
        JUMP_J    = 2'd1,
        JUMP_JR   = 2'd2,
        JUMP_RSVD = 2'd3
    } jump_e;

    typedef enum logic [1:0] {
        NPC_BRANCH = 2'd0,
        NPC_J      = 2'd1,
        NPC_JR     = 2'd2
    } npc_sel_e;

    // Sign-extended word offset of a branch immediate, in bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ifu_if
// Description : Fetch-side bundle between the IFU, instruction memory and decode.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_if;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [1:0]  is_jump;
    logic        branch_cond;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_err;

    modport master (
        input  stall, pc_sel, is_jump, branch_cond, jr_target, imem_rdata,
        output imem_addr, imem_en, instr, pc, pc_plus4, instr_valid, fetch_err
    );

    modport slave (
        output stall, pc_sel, is_jump, branch_cond, jr_target, imem_rdata,
        input  imem_addr, imem_en, instr, pc, pc_plus4, instr_valid, fetch_err
    );
endinterface
`default_nettype wire

// File: rtl/ifu_npc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ifu_npc
// Description : Combinational next-PC target select for branch, j and jr.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_npc
    import ifu_pkg::*;
(
    input  wire logic [31:0] i_pc_plus4,
    input  wire logic [25:0] i_instr_idx,
    input  wire logic [31:0] i_jr_target,
    input  wire npc_sel_e    i_sel,
    output logic [31:0]      o_target,
    output logic             o_misalign
);

    logic [31:0] w_raw;

    always_comb begin
        w_raw = i_pc_plus4 + branch_offset(i_instr_idx[15:0]);
        case (i_sel)
            NPC_J:   w_raw = {i_pc_plus4[31:28], i_instr_idx, 2'b00};
            NPC_JR:  w_raw = i_jr_target;
            default: w_raw = i_pc_plus4 + branch_offset(i_instr_idx[15:0]);
        endcase
    end

    // Only jr can produce a misaligned target; the low bits are dropped on load
    assign o_target   = {w_raw[31:2], 2'b00};
    assign o_misalign = |w_raw[1:0];

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ifu
// Description : Instruction fetch unit: PC, sync-read imem drive, redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    ifu_if.master     bus
);

    logic [31:0] r_pc_f;
    logic [31:0] r_pc_d;
    logic        r_valid_d;
    logic        r_err;

    logic [31:0] w_pc_plus4;
    jump_e       w_jump;
    logic        w_is_j;
    logic        w_is_jr;
    logic        w_br_taken;
    logic        w_redir;
    npc_sel_e    w_sel;
    logic [31:0] w_target;
    logic        w_misalign;

    assign w_pc_plus4 = r_pc_d + 32'd4;
    assign w_jump     = jump_e'(bus.is_jump);
    assign w_is_j     = (w_jump == JUMP_J);
    assign w_is_jr    = (w_jump == JUMP_JR);
    assign w_br_taken = (bus.pc_sel == PC_MUX_SEL_BRANCH) && bus.branch_cond;

    // Decode inputs are meaningless during a bubble, hence the valid_d gate
    assign w_redir = r_valid_d && !bus.stall && (w_is_j || w_is_jr || w_br_taken);

    assign w_sel = w_is_jr ? NPC_JR : (w_is_j ? NPC_J : NPC_BRANCH);

    ifu_npc u_npc (
        .i_pc_plus4  (w_pc_plus4),
        .i_instr_idx (bus.imem_rdata[25:0]),
        .i_jr_target (bus.jr_target),
        .i_sel       (w_sel),
        .o_target    (w_target),
        .o_misalign  (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f    <= RESET_PC;
            r_pc_d    <= RESET_PC;
            r_valid_d <= 1'b0;
            r_err     <= 1'b0;
        end else if (!bus.stall) begin
            r_pc_d <= r_pc_f;
            if (w_redir) begin
                // The fetch already in flight is the squashed slot
                r_valid_d <= 1'b0;
                r_pc_f    <= w_target;
                r_err     <= r_err | w_misalign;
            end else begin
                r_valid_d <= 1'b1;
                r_pc_f    <= r_pc_f + 32'd4;
            end
        end
    end

    assign bus.imem_addr   = r_pc_f;
    assign bus.imem_en     = rst | !bus.stall;
    assign bus.instr       = bus.imem_rdata;
    assign bus.pc          = r_pc_d;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.instr_valid = r_valid_d;
    assign bus.fetch_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ifu
// Description : Scoreboard bench for ifu; two instances with different reset PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] C_RPC0 = 32'h0000_3000;
    localparam logic [31:0] C_RPC1 = 32'hFFFF_FFF8;

    typedef struct packed {
        logic        en;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    logic done;
    int   n_checks;
    int   n_errors;
    int   n_popped;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: what each DUT presents in the coming cycle
    logic        m_vld[2];
    logic [31:0] m_pc[2];
    logic [31:0] m_fa[2];
    logic        m_err[2];
    logic        m_init;

    ifu_if ifc0 ();
    ifu_if ifc1 ();

    ifu #(.RESET_PC(C_RPC0)) u_dut0 (.clk(clk), .rst(rst), .bus(ifc0.master));
    ifu #(.RESET_PC(C_RPC1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifc1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3008) return 32'h1000_FFFE;   // beq, imm = -2
        if (a == 32'h0000_3010) return 32'h0800_0C40;   // j 0x3100
        if (a >= 32'h0000_3000 && a < 32'h0000_4000) return (a - 32'h0000_3000) >> 2;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (ifc0.imem_en) ifc0.imem_rdata <= mem_word(ifc0.imem_addr);
        if (ifc1.imem_en) ifc1.imem_rdata <= mem_word(ifc1.imem_addr);
    end

    function automatic logic [31:0] rpc(input int d);
        return (d == 0) ? C_RPC0 : C_RPC1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_vld[d] = 1'b0;
            m_pc[d]  = rpc(d);
            m_fa[d]  = rpc(d);
            m_err[d] = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, record what the DUTs must show, advance the model
    task automatic step(input logic r, input logic s, input logic [1:0] ps,
                        input logic [1:0] ij, input logic bc, input logic [31:0] jt);
        exp_t        e;
        logic [31:0] w;
        logic [31:0] p4;
        logic [31:0] t;
        int          off;
        @(posedge clk);
        #1;
        rst = r;
        ifc0.stall = s;  ifc0.pc_sel = ps; ifc0.is_jump = ij; ifc0.branch_cond = bc; ifc0.jr_target = jt;
        ifc1.stall = s;  ifc1.pc_sel = ps; ifc1.is_jump = ij; ifc1.branch_cond = bc; ifc1.jr_target = jt;
        for (int d = 0; d < 2; d++) begin
            if (m_init) begin
                e.en    = r | ~s;
                e.vld   = m_vld[d];
                e.pc    = m_pc[d];
                e.pc4   = m_pc[d] + 32'd4;
                e.instr = mem_word(m_pc[d]);
                e.addr  = m_fa[d];
                e.err   = m_err[d];
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            if (!r && !s) begin
                if (m_vld[d] && (ij == 2'd1 || ij == 2'd2 || (ps == 2'b01 && bc))) begin
                    w  = mem_word(m_pc[d]);
                    p4 = m_pc[d] + 32'd4;
                    if (ij == 2'd2)      t = jt;
                    else if (ij == 2'd1) t = {p4[31:28], w[25:0], 2'b00};
                    else begin
                        off = $signed(w[15:0]);
                        t   = p4 + 32'(off * 4);
                    end
                    if (t % 4 != 0) m_err[d] = 1'b1;
                    t = t - (t % 4);
                    m_pc[d]  = m_fa[d];
                    m_vld[d] = 1'b0;
                    m_fa[d]  = t;
                end else begin
                    m_pc[d]  = m_fa[d];
                    m_vld[d] = 1'b1;
                    m_fa[d]  = m_fa[d] + 32'd4;
                end
            end
        end
        if (r) begin
            model_reset();
            m_init = 1'b1;
        end
    endtask

    task automatic run_until(input logic [31:0] a);
        for (int i = 0; i < 40; i++) begin
            if (m_vld[0] && m_pc[0] == a) return;
            step(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        end
        $display("FAIL wait_pc: reference never presented %h within 40 cycles (last %h)", a, m_pc[0]);
        $fatal(1, "bench sequencing stalled");
    endtask

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        logic [31:0] jt;
        done   = 1'b0;
        m_init = 1'b0;
        rst    = 1'b1;
        ifc0.stall = 1'b0; ifc0.pc_sel = 2'b00; ifc0.is_jump = 2'b00; ifc0.branch_cond = 1'b0; ifc0.jr_target = 32'h0;
        ifc1.stall = 1'b0; ifc1.pc_sel = 2'b00; ifc1.is_jump = 2'b00; ifc1.branch_cond = 1'b0; ifc1.jr_target = 32'h0;
        model_reset();
        m_init = 1'b1;

        step(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
        run_until(32'h0000_3008);
        step(1'b0, 1'b0, PC_MUX_SEL_BRANCH, 2'b00, 1'b1, 32'h0);      // beq taken -> 0x3004
        run_until(32'h0000_3008);
        step(1'b0, 1'b0, PC_MUX_SEL_BRANCH, 2'b00, 1'b0, 32'h0);      // beq not taken
        run_until(32'h0000_3010);
        step(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 32'h0);                  // j -> 0x3100
        run_until(32'h0000_3100);
        step(1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0000_3202);          // misaligned jr
        run_until(32'h0000_3200);
        step(1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0000_3010);
        run_until(32'h0000_3010);
        repeat (3) step(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 32'h0);       // stalled j
        step(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 32'h0);
        run_until(32'h0000_3100);
        step(1'b1, 1'b1, PC_MUX_SEL_BRANCH, 2'b10, 1'b1, 32'h0000_4000);

        for (int i = 0; i < 1500; i++) begin
            jt = $urandom;
            if ($urandom_range(0, 7) != 0) jt[1:0] = 2'b00;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 2'($urandom), 2'($urandom), 1'($urandom), jt);
        end
        @(posedge clk);
        #1;
        done = 1'b1;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic cmp(input int d, input exp_t e, input logic en, input logic vld,
                       input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins,
                       input logic [31:0] addr, input logic err);
        n_popped++;
        chk("imem_en",     d, {31'd0, en},  {31'd0, e.en});
        chk("instr_valid", d, {31'd0, vld}, {31'd0, e.vld});
        chk("pc",          d, pc,   e.pc);
        chk("pc_plus4",    d, pc4,  e.pc4);
        chk("imem_addr",   d, addr, e.addr);
        chk("fetch_err",   d, {31'd0, err}, {31'd0, e.err});
        if (e.vld) chk("instr", d, ins, e.instr);
    endtask

    // Monitor: one expected entry per DUT per cycle, compared mid-cycle
    initial begin
        n_checks = 0;
        n_errors = 0;
        n_popped = 0;
        forever begin
            @(negedge clk);
            if (q0.size() > 0)
                cmp(0, q0.pop_front(), ifc0.imem_en, ifc0.instr_valid, ifc0.pc, ifc0.pc_plus4,
                    ifc0.instr, ifc0.imem_addr, ifc0.fetch_err);
            if (q1.size() > 0)
                cmp(1, q1.pop_front(), ifc1.imem_en, ifc1.instr_valid, ifc1.pc, ifc1.pc_plus4,
                    ifc1.instr, ifc1.imem_addr, ifc1.fetch_err);
            if (done) begin
                chk("sb_drain", 0, 32'(q0.size() + q1.size()), 32'd0);
                chk("sb_count", 0, 32'(n_popped > 2000), 32'd1);
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        end
    end

endmodule
`default_nettype wire
